// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 round/pack stage: rounding-mode
// encodings, fflags bit positions, IEEE-754 constants and the stage-1 payload.
package fp_pkg;

  // RISC-V rounding-mode encodings (101-111 are handled as RNE downstream)
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // fflags bit positions {NV,DZ,OF,UF,NX}
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam int FP32_BIAS    = 127;
  localparam int FP32_EXP_MAX = 255;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

  // Internal exponent width: wide enough for the input exponent (up to 11
  // bits) plus the normalize increment and the round carry without wrapping.
  localparam int S1_EXP_W = 12;
  typedef logic signed [S1_EXP_W-1:0] s1_exp_t;

  // Normalized, pre-rounding operation held between the two stages
  typedef struct packed {
    logic        sign;
    s1_exp_t     exp;
    logic [23:0] sig24;
    logic        g;
    logic        r;
    logic        s;
    logic        tiny;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        invalid;
    logic [2:0]  rm;
  } s1_payload_t;

endpackage

// File: rtl/fp_round_decide.sv
// Rounding decision: given the rounding mode, sign, significand LSB and the
// guard/round/sticky bits, decide whether to increment and whether inexact.
module fp_round_decide
  import fp_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  output logic       inc,
  output logic       inexact
);

  // Increment rule per rounding mode; unknown codes fall back to RNE
  always_comb begin
    inexact = g | r | s;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fp32_round_pack_unit.sv
// Round-and-pack stage after the FP32 multiplier datapath.
// Stage 1 normalizes the raw 48-bit product (incl. denormalizing shift),
// stage 2 rounds per rm and packs binary32 + fflags.
// Handshake: an input transfers on valid_i & ready_o, a result on
// valid_o & ready_i; valid_o/result_o/fflags_o stay stable while
// valid_o & !ready_i; in and out transfers in one cycle sustain 1 op/cycle.
// Optional macro ROUND_PACK_FLUSH_EN adds flush_i, which clears both stages
// and blocks input acceptance in the same cycle.
module fp32_round_pack_unit
  import fp_pkg::*;
#(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 48
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef ROUND_PACK_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [MANT_W-1:0] mant_i,
  input  logic              is_nan_i,
  input  logic              is_inf_i,
  input  logic              is_zero_i,
  input  logic              invalid_i,
  input  logic [2:0]        rm_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       result_o,
  output logic [4:0]        fflags_o
);

  logic        s1_valid;
  s1_payload_t s1_q;
  s1_payload_t s1_d;
  logic        s2_adv;

  // Stage-1 working values
  s1_exp_t     exp_ext;
  s1_exp_t     n_exp;
  s1_exp_t     sh_raw;
  logic [23:0] n_sig;
  logic        n_g, n_r, n_s;
  logic [4:0]  sh_amt;
  logic [51:0] sh_vec;

  // Stage-2 working values
  logic        rnd_inc;
  logic        rnd_inexact;
  logic [24:0] rnd_sum;
  s1_exp_t     rnd_exp;
  logic [22:0] rnd_frac;
  logic        rnd_ovf;
  logic        ovf_to_inf;
  logic [31:0] s2_result;
  logic [4:0]  s2_flags;

  // Output register moves whenever it is empty or being drained
  assign s2_adv = ~valid_o | ready_i;
`ifdef ROUND_PACK_FLUSH_EN
  assign ready_o = (~s1_valid | s2_adv) & ~flush_i;
`else
  assign ready_o = ~s1_valid | s2_adv;
`endif

  // Normalize: fold an overflowed product, extract G/R/S, denormalize tiny values
  always_comb begin
    exp_ext = {{(S1_EXP_W-EXP_W){exp_i[EXP_W-1]}}, exp_i};
    if (mant_i[MANT_W-1]) begin
      n_sig = mant_i[MANT_W-1 -: 24];
      n_g   = mant_i[MANT_W-25];
      n_r   = mant_i[MANT_W-26];
      n_s   = |mant_i[MANT_W-27:0];
      n_exp = exp_ext + s1_exp_t'(1);
    end else begin
      n_sig = mant_i[MANT_W-2 -: 24];
      n_g   = mant_i[MANT_W-26];
      n_r   = mant_i[MANT_W-27];
      n_s   = |mant_i[MANT_W-28:0];
      n_exp = exp_ext;
    end
    // Beyond 26 positions every significand/G/R bit is already in sticky
    sh_raw = s1_exp_t'(1) - n_exp;
    sh_amt = (sh_raw > s1_exp_t'(26)) ? 5'd26 : sh_raw[4:0];
    sh_vec = {n_sig, n_g, n_r, 26'd0} >> sh_amt;

    s1_d         = '0;
    s1_d.sign    = sign_i;
    s1_d.rm      = rm_i;
    s1_d.is_nan  = is_nan_i;
    s1_d.is_inf  = is_inf_i;
    s1_d.is_zero = is_zero_i;
    s1_d.invalid = invalid_i;
    if (n_exp <= s1_exp_t'(0)) begin
      s1_d.exp   = '0;
      s1_d.sig24 = sh_vec[51:28];
      s1_d.g     = sh_vec[27];
      s1_d.r     = sh_vec[26];
      s1_d.s     = n_s | (|sh_vec[25:0]);
      s1_d.tiny  = 1'b1;
    end else begin
      s1_d.exp   = n_exp;
      s1_d.sig24 = n_sig;
      s1_d.g     = n_g;
      s1_d.r     = n_r;
      s1_d.s     = n_s;
      s1_d.tiny  = 1'b0;
    end
  end

  // Stage-1 register: refills whenever it is empty or handing off
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
`ifdef ROUND_PACK_FLUSH_EN
      if (flush_i) s1_valid <= 1'b0;
      else
`endif
      if (ready_o) begin
        s1_valid <= valid_i;
        if (valid_i) s1_q <= s1_d;
      end
    end
  end

  fp_round_decide u_round_decide (
    .rm      (s1_q.rm),
    .sign    (s1_q.sign),
    .lsb     (s1_q.sig24[0]),
    .g       (s1_q.g),
    .r       (s1_q.r),
    .s       (s1_q.s),
    .inc     (rnd_inc),
    .inexact (rnd_inexact)
  );

  // Round, handle carry-out / subnormal promotion / overflow, then pack
  always_comb begin
    rnd_sum  = {1'b0, s1_q.sig24} + {24'd0, rnd_inc};
    rnd_exp  = s1_q.exp;
    rnd_frac = rnd_sum[22:0];
    if (rnd_sum[24]) begin
      rnd_exp  = s1_q.exp + s1_exp_t'(1);
      rnd_frac = '0;
    end else if ((s1_q.exp == s1_exp_t'(0)) && rnd_sum[23]) begin
      rnd_exp = s1_exp_t'(1);
    end
    rnd_ovf = (rnd_exp >= s1_exp_t'(FP32_EXP_MAX));

    case (s1_q.rm)
      RM_RTZ:  ovf_to_inf = 1'b0;
      RM_RDN:  ovf_to_inf = s1_q.sign;
      RM_RUP:  ovf_to_inf = ~s1_q.sign;
      default: ovf_to_inf = 1'b1;
    endcase

    s2_result = '0;
    s2_flags  = '0;
    if (s1_q.is_nan) begin
      s2_result        = CANON_NAN;
      s2_flags[FF_NV]  = s1_q.invalid;
    end else if (s1_q.is_inf) begin
      s2_result = {s1_q.sign, 8'hFF, 23'd0};
    end else if (s1_q.is_zero) begin
      s2_result = {s1_q.sign, 31'd0};
    end else if (rnd_ovf) begin
      s2_result       = ovf_to_inf ? {s1_q.sign, 8'hFF, 23'd0} : {s1_q.sign, MAX_FINITE[30:0]};
      s2_flags[FF_OF] = 1'b1;
      s2_flags[FF_NX] = 1'b1;
    end else begin
      s2_result       = {s1_q.sign, rnd_exp[7:0], rnd_frac};
      s2_flags[FF_UF] = s1_q.tiny & rnd_inexact;
      s2_flags[FF_NX] = rnd_inexact;
    end
  end

  // Output register: loads from stage 1 when free, holds under backpressure
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      result_o <= '0;
      fflags_o <= '0;
    end else begin
`ifdef ROUND_PACK_FLUSH_EN
      if (flush_i) valid_o <= 1'b0;
      else
`endif
      if (s2_adv) begin
        valid_o <= s1_valid;
        if (s1_valid) begin
          result_o <= s2_result;
          fflags_o <= s2_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_round_pack_unit.sv
// Bench for fp32_round_pack_unit: directed vectors with literal expectations,
// an exact-arithmetic reference model feeding an expected queue, and one
// monitor comparing every valid output cycle (including held cycles).
module tb_fp32_round_pack_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [9:0]  exp_i;
  logic [47:0] mant_i;
  logic        is_nan_i, is_inf_i, is_zero_i, invalid_i;
  logic [2:0]  rm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  logic [36:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [47:0] M_15X15 = 48'h900000000000;
  localparam logic [47:0] M_TIE   = 48'h400000C00000;
  localparam logic [47:0] M_ONE   = 48'h400000000000;
  localparam logic [47:0] M_SUB   = 48'h400000000001;
  localparam logic [47:0] M_ONES  = 48'h7FFFFFFFFFFF;
  localparam logic [47:0] M_HI    = 48'hC00000000001;

  fp32_round_pack_unit dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .sign_i    (sign_i),
    .exp_i     (exp_i),
    .mant_i    (mant_i),
    .is_nan_i  (is_nan_i),
    .is_inf_i  (is_inf_i),
    .is_zero_i (is_zero_i),
    .invalid_i (invalid_i),
    .rm_i      (rm_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .fflags_o  (fflags_o)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: value = mant * 2^(exp-173); quantize to the binary32 grid of
  // the target binade using exact integer quotient/remainder.
  function automatic logic [36:0] model(input logic s, input int e, input logic [47:0] m,
                                        input logic [3:0] sp, input logic [2:0] rm);
    int big_e, base, k, field;
    logic [63:0] mm, n, rem, half;
    logic inc, inexact, tiny, to_inf;
    if (sp[3]) return {32'h7FC00000, sp[0], 4'b0};
    if (sp[2]) return {s, 31'h7F800000, 5'b0};
    if (sp[1]) return {s, 31'h0, 5'b0};
    big_e = e + (m[47] ? 1 : 0);
    base  = (big_e < 1) ? 1 : big_e;
    k     = base - e + 23;
    if (k > 60) k = 60;
    mm      = {16'd0, m};
    n       = mm >> k;
    rem     = mm - (n << k);
    half    = 64'd1 << (k - 1);
    inexact = (rem != 0);
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = inexact & s;
      3'd3:    inc = inexact & !s;
      3'd4:    inc = (rem >= half);
      default: inc = (rem > half) || ((rem == half) && n[0]);
    endcase
    n = n + {63'd0, inc};
    if (n >= 64'h1000000)     field = base + 1;
    else if (n >= 64'h800000) field = base;
    else                      field = 0;
    tiny = (big_e < 1);
    if (field >= 255) begin
      to_inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? s : (rm == 3'd3) ? !s : 1'b1;
      return {(to_inf ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF}), 5'b00101};
    end
    return {s, 8'(field), n[22:0], 3'b000, tiny & inexact, inexact};
  endfunction

  // driver: present one op and hold it until it is accepted
  task automatic send(input logic s, input int e, input logic [47:0] m,
                      input logic [3:0] sp, input logic [2:0] rm);
    int  n;
    bit  done;
    sign_i = s;
    exp_i  = 10'(e);
    mant_i = m;
    {is_nan_i, is_inf_i, is_zero_i, invalid_i} = sp;
    rm_i    = rm;
    valid_i = 1'b1;
    n    = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (ready_o) begin
        exp_q.push_back(model(s, e, m, sp, rm));
        done = 1;
      end else begin
        n++;
        if (n >= 50) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: ready_o stayed %0b for %0d cycles, required 1", ready_o, n);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  // driver with a hand-computed literal that pins the model first
  task automatic pin(input string name, input logic s, input int e, input logic [47:0] m,
                     input logic [3:0] sp, input logic [2:0] rm, input logic [36:0] lit);
    logic [36:0] got;
    got = model(s, e, m, sp, rm);
    checks++;
    if (got !== lit) begin
      errors++;
      $display("FAIL model_%s: model gives %h/%h, hand value %h/%h", name,
               got[36:5], got[4:0], lit[36:5], lit[4:0]);
    end
    send(s, e, m, sp, rm);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, act, req);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every cycle with valid_o is compared to the queue head
  always @(negedge clk) begin
    if (!rst_i && valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h/%h, required no valid output", result_o, fflags_o);
      end else begin
        if ({result_o, fflags_o} !== exp_q[0]) begin
          errors++;
          $display("FAIL result: got %h/%h, required %h/%h", result_o, fflags_o,
                   exp_q[0][36:5], exp_q[0][4:0]);
        end
        if (ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // clock/reset
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    sign_i  = 1'b0;
    exp_i   = '0;
    mant_i  = '0;
    {is_nan_i, is_inf_i, is_zero_i, invalid_i} = 4'b0;
    rm_i    = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_valid_o", valid_o, 1'b0);
    checks++;
    if (result_o !== 32'd0 || fflags_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h, required 00000000/00", result_o, fflags_o);
    end
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // latency: accepted at edge A, visible after edge A+1
    pin("mul15", 0, 127, M_15X15, 4'b0000, 3'd0, {32'h40100000, 5'h00});
    check1("latency_not_early", valid_o, 1'b0);
    @(posedge clk);
    #1;
    check1("latency_2", valid_o, 1'b1);
    wait_drain();

    // back-to-back directed vectors
    pin("tie_rne",  0, 127, M_TIE, 4'b0000, 3'd0, {32'h3F800002, 5'h01});
    pin("tie_rtz",  0, 127, M_TIE, 4'b0000, 3'd1, {32'h3F800001, 5'h01});
    pin("tie_rmm",  0, 127, M_TIE, 4'b0000, 3'd4, {32'h3F800002, 5'h01});
    pin("tie_rdn_n",1, 127, M_TIE, 4'b0000, 3'd2, {32'hBF800002, 5'h01});
    pin("tie_rup_n",1, 127, M_TIE, 4'b0000, 3'd3, {32'hBF800001, 5'h01});
    pin("tie_rm7",  0, 127, M_TIE, 4'b0000, 3'd7, {32'h3F800002, 5'h01});
    pin("ovf_rne",  0, 300, M_ONE, 4'b0000, 3'd0, {32'h7F800000, 5'h05});
    pin("ovf_rtz",  0, 300, M_ONE, 4'b0000, 3'd1, {32'h7F7FFFFF, 5'h05});
    pin("ovf_rup_n",1, 300, M_ONE, 4'b0000, 3'd3, {32'hFF7FFFFF, 5'h05});
    pin("ovf_rdn_p",0, 300, M_ONE, 4'b0000, 3'd2, {32'h7F7FFFFF, 5'h05});
    pin("ovf_rdn_n",1, 300, M_ONE, 4'b0000, 3'd2, {32'hFF800000, 5'h05});
    pin("sub_rne",  0, -2,  M_SUB, 4'b0000, 3'd0, {32'h00100000, 5'h03});
    pin("sub_exact",0, -1,  M_ONE, 4'b0000, 3'd0, {32'h00200000, 5'h00});
    pin("sub_to_1", 0, 0,   M_ONES, 4'b0000, 3'd0, {32'h00800000, 5'h03});
    pin("carry",    0, 127, M_ONES, 4'b0000, 3'd0, {32'h40000000, 5'h01});
    pin("ovf_rnd",  0, 254, M_ONES, 4'b0000, 3'd0, {32'h7F800000, 5'h05});
    pin("deep_rne", 0, -300, M_ONE, 4'b0000, 3'd0, {32'h00000000, 5'h03});
    pin("deep_rup", 0, -300, M_ONE, 4'b0000, 3'd3, {32'h00000001, 5'h03});
    pin("m47_rne",  0, 126, M_HI,  4'b0000, 3'd0, {32'h3FC00000, 5'h01});
    pin("m47_rup",  0, 126, M_HI,  4'b0000, 3'd3, {32'h3FC00001, 5'h01});
    pin("nan_nv",   0, 127, M_ONE, 4'b1001, 3'd0, {32'h7FC00000, 5'h10});
    pin("nan_prio", 1, 300, M_ONE, 4'b1110, 3'd3, {32'h7FC00000, 5'h00});
    pin("inf_neg",  1, 127, M_ONE, 4'b0110, 3'd0, {32'hFF800000, 5'h00});
    pin("zero_neg", 1, 127, M_ONE, 4'b0010, 3'd0, {32'h80000000, 5'h00});
    wait_drain();

    // backpressure: consumer stalls for 4 cycles while 3 ops are offered
    ready_i = 1'b0;
    fork
      begin
        send(0, 127, M_15X15, 4'b0000, 3'd0);
        send(0, 127, M_TIE,   4'b0000, 3'd1);
        send(0, -2,  M_SUB,   4'b0000, 3'd0);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check1("bp_ready_low", ready_o, 1'b0);
        checks++;
        if (exp_q.size() != 2) begin
          errors++;
          $display("FAIL bp_accepted: got %0d accepted, required 2", exp_q.size());
        end
        ready_i = 1'b1;
      end
    join
    wait_drain();

    // reset in the middle of a stream
    send(0, 127, M_TIE, 4'b0000, 3'd0);
    send(1, 300, M_ONE, 4'b0000, 3'd0);
    check1("pre_reset_valid", valid_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check1("reset_mid_valid_o", valid_o, 1'b0);
    checks++;
    if (result_o !== 32'd0 || fflags_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h/%h, required 00000000/00", result_o, fflags_o);
    end
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check1("no_stale_after_reset", valid_o, 1'b0);

    // pipeline still works after reset
    send(0, 127, M_15X15, 4'b0000, 3'd0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_round_pack_unit.md
Name: fp32_round_pack_unit

Overview:
- Execute-stage stage directly downstream of the float multiplication datapath.
- Consumes an unrounded product: sign, unbiased-sum exponent, raw 48-bit mantissa product, special-case flags.
- Normalizes, rounds per RISC-V rm, and packs an IEEE-754 binary32 result plus fflags for the writeback path.
- Two-stage pipeline with valid/ready backpressure.

Parameters:
- EXP_W, 10, width of signed exponent input (two's complement).
- MANT_W, 48, width of raw mantissa product (hidden bits at [47:46]).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- valid_i  in  1  input operation valid
- ready_o  out  1  block can accept input this cycle
- sign_i  in  1  product sign
- exp_i  in  EXP_W  biased exponent sum minus bias (e1+e2-127), signed
- mant_i  in  MANT_W  raw 24x24 mantissa product
- is_nan_i  in  1  result is NaN
- is_inf_i  in  1  result is infinity
- is_zero_i  in  1  result is zero
- invalid_i  in  1  invalid operation detected upstream (sNaN operand, inf*0)
- rm_i  in  3  rounding mode
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  32  packed binary32
- fflags_o  out  5  {NV,DZ,OF,UF,NX}, bit4..bit0

Behaviour:
- Reset: s1/s2 valid=0; valid_o=0, result_o=0, fflags_o=0. Reset mid-operation discards all in-flight ops.
- Handshake:
  - Transfer in on valid_i&ready_o; out on valid_o&ready_i.
  - ready_o = !s1_valid | (s1 advances), where s1 advances when !s2_valid | ready_i.
  - Latency 2 cycles with no stall.
  - valid_o, result_o and fflags_o are held stable while valid_o&!ready_i.
  - Simultaneous in and out transfers in the same cycle sustain 1 op/cycle.
- Stage 1 (normalize):
  - If mant[47]=1: shift right 1, exp+1.
  - Take 24-bit significand, guard bit, round bit and sticky (OR of the remaining bits).
  - If exp<=0: shift right by (1-exp), capped at 26; shifted-out bits OR into sticky; exp=0; tiny=1 (tininess detected before rounding).
- Stage 2 (round):
  - rm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM. Codes 101-111 are treated as RNE (decode traps them).
  - inc per rm/sign/LSB/G/R/S. Inexact = G|R|S.
  - Significand carry-out: exp+1, fraction=0.
  - Subnormal rounding up into 1.0: exp field 1.
  - exp>=255 after rounding gives overflow, with OF|NX set:
    - result is Inf for RNE/RMM, for RUP with positive sign, and for RDN with negative sign;
    - otherwise result is max finite 0x7F7FFFFF with sign.
  - UF = tiny & inexact. NX is set whenever inexact or OF.
- Special cases (priority nan > inf > zero):
  - NaN gives 0x7FC00000, NV=invalid_i.
  - Inf gives sign|0x7F800000.
  - Zero gives sign<<31.
  - In all special cases every other flag is 0.
- DZ is always 0.

Optional Feature:
- ROUND_PACK_FLUSH_EN
- Defined: adds input flush_i (1 bit). When flush_i=1, both stage valids clear on the next edge and the input is not accepted that cycle. Flush has priority over a concurrent in/out transfer.
- Undefined: no flush_i port; ops leave only by handshake.

Decomposition:
- fp_pkg holds:
  - rm encodings (RM_RNE..RM_RMM);
  - fflag bit indices;
  - FP32_BIAS=127, FP32_EXP_MAX=255;
  - CANON_NAN=32'h7FC00000, MAX_FINITE=32'h7F7FFFFF;
  - stage-1 payload struct (sign, exp, sig24, g, r, s, tiny, special flags, rm).
- One combinational sub-module, fp_round_decide: (rm, sign, lsb, g, r, s) -> inc, inexact.

Test Plan:
- 1.5*1.5: sign 0, exp_i=127, mant_i=48'h900000000000, RNE -> result 0x40100000, fflags 0x00 after 2 cycles.
- Tie case: exp_i=127, mant_i[46:23]=24'h800001, guard=1, lower bits 0:
  - RNE -> 0x3F800002, fflags 0x01;
  - RTZ -> 0x3F800001, fflags 0x01.
- Overflow: exp_i=300, mant_i=48'h400000000000:
  - RNE -> 0x7F800000, fflags 0x05;
  - RTZ -> 0x7F7FFFFF, fflags 0x05;
  - sign=1 with RUP -> 0xFF7FFFFF.
- Subnormal: exp_i=-2, mant_i=48'h400000000001, RNE -> 0x00100000, fflags 0x03 (UF|NX).
- Special: is_nan_i=1 with invalid_i=1 -> 0x7FC00000, 0x10; is_zero_i=1 with sign=1 -> 0x80000000, 0x00.
- Backpressure/reset:
  - Issue 3 back-to-back ops with ready_i=0 for 4 cycles -> ready_o low after 2 accepted; outputs held stable; all 3 results emerge in order when ready_i=1.
  - Assert rst_i mid-stream -> valid_o=0 immediately; no stale result after reset release.
